// File: rtl/dmem_sized.sv
// dmem_sized: byte-addressed data memory with byte/half/word(/dword) loads and stores,
// sign/zero-extended loads, misalignment flagging and a sequential clear sweep after rst.
// Optional feature macro: DMEM_PARITY_EN adds per-byte even parity (inj_perr_i / perr_o).
module dmem_sized #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DEPTH_LOG2 = 12,
    // Derived byte-address width; not meant to be overridden.
    parameter int unsigned ADDR_W     = DEPTH_LOG2 + $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ready_o,
    input  logic              en_i,
    input  logic              re_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [1:0]        size_i,
    input  logic              uns_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rvalid_o,
`ifdef DMEM_PARITY_EN
    input  logic              inj_perr_i,
    output logic              perr_o,
`endif
    output logic              err_o
);

    localparam int unsigned LANES = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(LANES);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

    typedef enum logic [0:0] {StClear, StIdle} state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  clr_cnt_q;
    logic              ready_q;
    logic              rvalid_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [DEPTH_LOG2-1:0] idx;
    logic [OFF_W-1:0]      off;
    logic                  accept;
    logic                  misalign;
    logic                  do_load;
    logic                  do_store;
    logic [LANES-1:0]      lane_mask;
    logic [DATA_W-1:0]     wdata_sh;
    logic [DATA_W-1:0]     rword;
    logic [DATA_W-1:0]     rshift;
    logic [DATA_W-1:0]     rdata_d;
    logic                  sign_bit;
    int                    nbytes;
    int                    offs;

    assign idx = addr_i[ADDR_W-1:OFF_W];
    assign off = addr_i[OFF_W-1:0];

    // Request decode, lane mask, store alignment and load extraction/extension.
    always_comb begin
        nbytes   = 1 << size_i;
        offs     = int'(off);
        accept   = en_i & ready_q & (re_i | we_i);
        misalign = 1'b0;
        unique case (size_i)
            2'd0:    misalign = 1'b0;
            2'd1:    misalign = addr_i[0];
            2'd2:    misalign = |addr_i[1:0];
            default: misalign = (DATA_W == 32) || (|addr_i[2:0]);
        endcase
        // re&we together performs the load and silently drops the store.
        do_load  = accept & re_i & ~misalign;
        do_store = accept & we_i & ~re_i & ~misalign;
        for (int i = 0; i < int'(LANES); i++) begin
            lane_mask[i] = (i >= offs) && (i < offs + nbytes);
        end
        wdata_sh = wdata_i << {off, 3'b000};
        rword    = mem_q[idx];
        rshift   = rword >> {off, 3'b000};
        unique case (size_i)
            2'd0:    sign_bit = rshift[7];
            2'd1:    sign_bit = rshift[15];
            2'd2:    sign_bit = rshift[31];
            default: sign_bit = rshift[DATA_W-1];
        endcase
        for (int b = 0; b < int'(DATA_W); b++) begin
            rdata_d[b] = (b < 8 * nbytes) ? rshift[b] : (~uns_i & sign_bit);
        end
    end

`ifdef DMEM_PARITY_EN
    logic [LANES-1:0] par_q [DEPTH];
    logic [LANES-1:0] wpar;
    logic [LANES-1:0] rpar_calc;
    logic             perr_d;
    logic             perr_q;

    // Even parity per byte; injection flips the parity of every written lane.
    always_comb begin
        for (int i = 0; i < int'(LANES); i++) begin
            wpar[i]      = (^wdata_sh[8*i +: 8]) ^ inj_perr_i;
            rpar_calc[i] = ^rword[8*i +: 8];
        end
        perr_d = |(lane_mask & (rpar_calc ^ par_q[idx]));
    end

    // Parity storage follows the data array: cleared by the sweep, lane-written on stores.
    always_ff @(posedge clk) begin
        if (state_q == StClear) begin
            par_q[clr_cnt_q[DEPTH_LOG2-1:0]] <= '0;
        end else if (do_store) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (lane_mask[i]) par_q[idx][i] <= wpar[i];
            end
        end
    end

    // Parity error flag pulses alongside rvalid.
    always_ff @(posedge clk) begin
        if (rst) perr_q <= 1'b0;
        else     perr_q <= do_load & perr_d;
    end

    assign perr_o = perr_q;
`endif

    // Data array: clear sweep has priority; stores update only masked byte lanes.
    always_ff @(posedge clk) begin
        if (state_q == StClear) begin
            mem_q[clr_cnt_q[DEPTH_LOG2-1:0]] <= '0;
        end else if (do_store) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (lane_mask[i]) mem_q[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
            end
        end
    end

    // Clear-sweep FSM plus registered response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StClear;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            rvalid_q <= do_load;
            err_q    <= accept & misalign;
            if (do_load) begin
                rdata_q <= rdata_d;
            end else if (accept & misalign) begin
                rdata_q <= '0;
            end
            case (state_q)
                StClear: begin
                    if (clr_cnt_q == CNT_W'(DEPTH - 1)) begin
                        state_q <= StIdle;
                        ready_q <= 1'b1;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + 1'b1;
                    end
                end
                default: ready_q <= 1'b1;
            endcase
        end
    end

    assign ready_o  = ready_q;
    assign rvalid_o = rvalid_q;
    assign err_o    = err_q;
    assign rdata_o  = rdata_q;

endmodule

// File: tb/tb_dmem_sized.sv
// Bench for dmem_sized (DATA_W=32, DEPTH_LOG2=4): reset sweep timing, table-driven
// load/store vectors through an expectation queue, misalignment and sweep restart.
module tb_dmem_sized;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned DEPTH_LOG2 = 4;
    localparam int unsigned ADDR_W     = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              ready;
    logic              en = 1'b0;
    logic              re = 1'b0;
    logic              we = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [1:0]        size = '0;
    logic              uns = 1'b0;
    logic [DATA_W-1:0] wdata = '0;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              err;
`ifdef DMEM_PARITY_EN
    logic              inj_perr = 1'b0;
    logic              perr;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        en, re, we;
        logic [5:0]  addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic        ev;   // expected rvalid
        logic        ee;   // expected err
        logic        cr;   // compare rdata
        logic [31:0] erd;  // expected rdata
    } vec_t;

    vec_t vecs[$];
    vec_t sb_q[$];

    dmem_sized #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ready_o  (ready),
        .en_i     (en),
        .re_i     (re),
        .we_i     (we),
        .addr_i   (addr),
        .size_i   (size),
        .uns_i    (uns),
        .wdata_i  (wdata),
        .rdata_o  (rdata),
        .rvalid_o (rvalid),
`ifdef DMEM_PARITY_EN
        .inj_perr_i (inj_perr),
        .perr_o     (perr),
`endif
        .err_o    (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic e, input logic r, input logic w, input logic [5:0] a,
                                input logic [1:0] s, input logic u, input logic [31:0] wd,
                                input logic ev, input logic ee, input logic cr,
                                input logic [31:0] erd);
        vec_t v;
        v.en = e; v.re = r; v.we = w; v.addr = a; v.size = s; v.uns = u; v.wdata = wd;
        v.ev = ev; v.ee = ee; v.cr = cr; v.erd = erd;
        return v;
    endfunction

    // Drive one request for one cycle, queue its expectation, then compare the response.
    task automatic apply(input vec_t v);
        vec_t e;
        @(negedge clk);
        en = v.en; re = v.re; we = v.we; addr = v.addr; size = v.size; uns = v.uns;
        wdata = v.wdata;
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        en = 1'b0; re = 1'b0; we = 1'b0;
        e = sb_q.pop_front();
        chk($sformatf("rvalid@%02h", e.addr), {31'd0, rvalid}, {31'd0, e.ev});
        chk($sformatf("err@%02h", e.addr), {31'd0, err}, {31'd0, e.ee});
        if (e.cr) chk($sformatf("rdata@%02h", e.addr), rdata, e.erd);
    endtask

    task automatic load(input logic [5:0] a, input logic [1:0] s, input logic u,
                        input logic [31:0] exp);
        apply(mk(1, 1, 0, a, s, u, 32'h0, 1, 0, 1, exp));
    endtask

    task automatic store(input logic [5:0] a, input logic [1:0] s, input logic [31:0] wd);
        apply(mk(1, 0, 1, a, s, 0, wd, 0, 0, 0, 32'h0));
    endtask

    // Pulse rst for one cycle; check reset values on the cycle after.
    task automatic pulse_rst(input string tag);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk({tag, "_ready"}, {31'd0, ready}, 32'd0);
        chk({tag, "_rvalid"}, {31'd0, rvalid}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
        chk({tag, "_rdata"}, rdata, 32'd0);
    endtask

    // Count ready-low cycles (including the one after the rst edge) until ready rises.
    task automatic count_sweep(input string tag, input int already);
        int cnt;
        bit seen;
        cnt  = already;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                seen = 1;
                break;
            end
            cnt++;
        end
        chk({tag, "_ready_rise"}, {31'd0, seen}, 32'd1);
        chk({tag, "_sweep_len"}, cnt, 32'd16);
    endtask

    initial begin
        // Reset sweep length and cleared contents.
        pulse_rst("rst1");
        count_sweep("rst1", 1);
        for (int w = 0; w < 16; w++) load(6'(w * 4), 2'd2, 1'b0, 32'h0);

        // Table of functional vectors: en re we addr size uns wdata | ev ee cr erd.
        vecs.push_back(mk(1, 0, 1, 6'h10, 2, 0, 32'h8899AABB, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 1, 0, 6'h13, 0, 0, 32'h0, 1, 0, 1, 32'hFFFFFF88));
        vecs.push_back(mk(1, 1, 0, 6'h13, 0, 1, 32'h0, 1, 0, 1, 32'h00000088));
        vecs.push_back(mk(1, 1, 0, 6'h10, 1, 0, 32'h0, 1, 0, 1, 32'hFFFFAABB));
        vecs.push_back(mk(1, 1, 0, 6'h12, 1, 1, 32'h0, 1, 0, 1, 32'h00008899));
        vecs.push_back(mk(1, 1, 0, 6'h11, 0, 0, 32'h0, 1, 0, 1, 32'hFFFFFFAA));
        vecs.push_back(mk(1, 0, 1, 6'h20, 2, 0, 32'h0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 1, 6'h21, 0, 0, 32'hFFFFFF5A, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 1, 0, 6'h20, 2, 0, 32'h0, 1, 0, 1, 32'h00005A00));
        vecs.push_back(mk(1, 1, 0, 6'h21, 1, 0, 32'h0, 0, 1, 1, 32'h0));
        vecs.push_back(mk(1, 0, 1, 6'h22, 2, 0, 32'hDEADBEEF, 0, 1, 0, 32'h0));
        vecs.push_back(mk(1, 1, 0, 6'h20, 2, 0, 32'h0, 1, 0, 1, 32'h00005A00));
        vecs.push_back(mk(0, 0, 0, 6'h00, 0, 0, 32'h0, 0, 0, 1, 32'h00005A00));
        vecs.push_back(mk(1, 1, 0, 6'h20, 3, 0, 32'h0, 0, 1, 1, 32'h0));
        vecs.push_back(mk(1, 1, 1, 6'h20, 2, 0, 32'hFFFFFFFF, 1, 0, 1, 32'h00005A00));
        vecs.push_back(mk(1, 1, 0, 6'h20, 2, 0, 32'h0, 1, 0, 1, 32'h00005A00));
        vecs.push_back(mk(1, 0, 1, 6'h26, 1, 0, 32'h1234BEEF, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 1, 0, 6'h24, 2, 0, 32'h0, 1, 0, 1, 32'hBEEF0000));
        vecs.push_back(mk(1, 1, 0, 6'h26, 1, 0, 32'h0, 1, 0, 1, 32'hFFFFBEEF));
        vecs.push_back(mk(1, 0, 1, 6'h3F, 0, 0, 32'h00000080, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 1, 0, 6'h3F, 0, 0, 32'h0, 1, 0, 1, 32'hFFFFFF80));
        vecs.push_back(mk(1, 1, 0, 6'h3C, 2, 0, 32'h0, 1, 0, 1, 32'h80000000));
        vecs.push_back(mk(1, 0, 0, 6'h3C, 2, 0, 32'h0, 0, 0, 1, 32'h80000000));
        vecs.push_back(mk(0, 1, 0, 6'h10, 2, 0, 32'h0, 0, 0, 1, 32'h80000000));
        vecs.push_back(mk(1, 1, 0, 6'h10, 2, 0, 32'h0, 1, 0, 1, 32'h8899AABB));
        foreach (vecs[i]) apply(vecs[i]);

`ifdef DMEM_PARITY_EN
        // Injected parity error on a byte store is reported on the load; clean store clears it.
        inj_perr = 1'b1;
        store(6'h30, 2'd0, 32'h01);
        inj_perr = 1'b0;
        load(6'h30, 2'd2, 1'b0, 32'h00000001);
        chk("perr_injected", {31'd0, perr}, 32'd1);
        store(6'h30, 2'd0, 32'h01);
        load(6'h30, 2'd2, 1'b0, 32'h00000001);
        chk("perr_clean", {31'd0, perr}, 32'd0);
`endif

        // Sweep restart: rst again at sweep cycle 5, with a request held during the sweep.
        pulse_rst("rst2");
        repeat (4) @(posedge clk);
        #1;
        chk("rst2_mid_ready", {31'd0, ready}, 32'd0);
        pulse_rst("rst3");
        en = 1'b1; re = 1'b1; addr = 6'h21; size = 2'd1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("ignored_rvalid", {31'd0, rvalid}, 32'd0);
            chk("ignored_err", {31'd0, err}, 32'd0);
        end
        count_sweep("rst3", 4);
        en = 1'b0; re = 1'b0;
        @(posedge clk);
        #1;
        chk("post_sweep_err", {31'd0, err}, 32'd0);
        load(6'h10, 2'd2, 1'b0, 32'h0);
        load(6'h20, 2'd2, 1'b0, 32'h0);
        load(6'h3C, 2'd2, 1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
